// File: rtl/fm_audio_pkg.sv
// rtl/fm_audio_pkg.sv - shared constants and types for the FM audio output stage
//
// Contents:
//   SAMPLE_W    width of each voice/filter sample and of the mixed level
//   MIX_SHIFT   right shift that brings the 14-bit mix sum back to SAMPLE_W
//   MIX_W       width of the un-shifted mix sum
//   PERIOD_MAX  last value of the period counter (period = PERIOD_MAX + 1)
//   mode_e      DAC modulation mode
//   gate_sample zero-extends a sample into the mix width, or yields 0 if disabled
package fm_audio_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int MIX_SHIFT = 2;
  localparam int MIX_W     = SAMPLE_W + MIX_SHIFT;

  localparam logic [SAMPLE_W-1:0] PERIOD_MAX = 12'd4094;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_DSM = 1'b1
  } mode_e;

  function automatic logic [MIX_W-1:0] gate_sample(input logic [SAMPLE_W-1:0] s,
                                                   input logic                en);
    return en ? {{MIX_SHIFT{1'b0}}, s} : '0;
  endfunction

endpackage

// File: rtl/fm_audio_dsm.sv
// rtl/fm_audio_dsm.sv - first-order delta-sigma accumulator for the audio DAC
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr         zero the accumulator (wins over en)
//   en          advance the accumulator by level this cycle
//   level       12-bit DC level to modulate
//   bit_out     carry of acc + level for the current cycle (combinational;
//               the top registers it into audio_out)
module fm_audio_dsm
  import fm_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] level,
  output logic                bit_out
);

  // Only the low 12 bits of the accumulator feed the next sum; the carry
  // bit is captured downstream as the audio_out register, so it is not
  // stored a second time here.
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, level};
  assign bit_out = acc_sum[SAMPLE_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/fm_audio_out.sv
// rtl/fm_audio_out.sv - voice mixer, peak meter and 1-bit PWM/delta-sigma DAC
//
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   sample_1..3        raw voice samples (12-bit unsigned)
//   sample_4           filter output (12-bit unsigned)
//   ch_en[3:0]         bit i-1 enables sample_i into the mix
//   mode               0 = PWM, 1 = delta-sigma; takes effect at the next hold load
//   peak_clr           one-cycle request to restart the peak meter
//   audio_out          registered 1-bit DAC bitstream
//   sample_tick        one-cycle pulse in the cycle after each hold load
//   peak               largest mix value since the last clear
module fm_audio_out
  import fm_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_1,
  input  logic [SAMPLE_W-1:0] sample_2,
  input  logic [SAMPLE_W-1:0] sample_3,
  input  logic [SAMPLE_W-1:0] sample_4,
  input  logic [3:0]          ch_en,
  input  logic                mode,
  input  logic                peak_clr,
  output logic                audio_out,
  output logic                sample_tick,
  output logic [SAMPLE_W-1:0] peak
);

  logic [MIX_W-1:0]    mix_sum;
  logic [SAMPLE_W-1:0] mix_q;
  logic [SAMPLE_W-1:0] cnt;
  logic [SAMPLE_W-1:0] hold;
  mode_e               mode_q;
  mode_e               mode_in;
  logic                period_end;
  logic                dsm_clr;
  logic                dsm_bit;

  // Four 12-bit values fit in 14 bits, so the sum never overflows.
  assign mix_sum = gate_sample(sample_1, ch_en[0])
                 + gate_sample(sample_2, ch_en[1])
                 + gate_sample(sample_3, ch_en[2])
                 + gate_sample(sample_4, ch_en[3]);

  assign mode_in    = mode_e'(mode);
  assign period_end = (cnt == PERIOD_MAX);
  // The accumulator restarts only when the load actually changes the mode,
  // so a steady DSM stream keeps its residue across periods.
  assign dsm_clr    = period_end && (mode_in != mode_q);

  fm_audio_dsm u_dsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (dsm_clr),
    .en      (mode_q == MODE_DSM),
    .level   (hold),
    .bit_out (dsm_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_q       <= '0;
      cnt         <= '0;
      hold        <= '0;
      mode_q      <= MODE_PWM;
      sample_tick <= 1'b0;
      audio_out   <= 1'b0;
      peak        <= '0;
    end else begin
      mix_q <= SAMPLE_W'(mix_sum >> MIX_SHIFT);

      if (period_end) begin
        cnt    <= '0;
        hold   <= mix_q;
        mode_q <= mode_in;
      end else begin
        cnt <= cnt + 1'b1;
      end
      sample_tick <= period_end;

      // cnt spans 0..4094, so hold = 4095 keeps the PWM output high all period.
      audio_out <= (mode_q == MODE_DSM) ? dsm_bit : (cnt < hold);

      if (peak_clr) begin
        peak <= mix_q;
      end else if (mix_q > peak) begin
        peak <= mix_q;
      end
    end
  end

endmodule

// File: tb/tb_fm_audio_out.sv
// tb/tb_fm_audio_out.sv - self-checking bench for fm_audio_out
module tb_fm_audio_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sample_1 = '0;
  logic [11:0] sample_2 = '0;
  logic [11:0] sample_3 = '0;
  logic [11:0] sample_4 = '0;
  logic [3:0]  ch_en = '0;
  logic        mode = 1'b0;
  logic        peak_clr = 1'b0;
  logic        audio_out;
  logic        sample_tick;
  logic [11:0] peak;

  int n_cmp = 0;
  int n_fail = 0;

  fm_audio_out dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_1    (sample_1),
    .sample_2    (sample_2),
    .sample_3    (sample_3),
    .sample_4    (sample_4),
    .ch_en       (ch_en),
    .mode        (mode),
    .peak_clr    (peak_clr),
    .audio_out   (audio_out),
    .sample_tick (sample_tick),
    .peak        (peak)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic: a 4095-cycle period phase,
  // a level latched at each period boundary, PWM as "phase below level",
  // delta-sigma as an integer accumulator modulo 4096 whose overflow is the bit.
  int m_mix, m_phase, m_hold, m_mode, m_acc, m_out, m_tick, m_peak;
  int t_sum, t_out, t_acc, t_peak;

  initial begin
    m_mix = 0; m_phase = 0; m_hold = 0; m_mode = 0;
    m_acc = 0; m_out = 0; m_tick = 0; m_peak = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mix = 0; m_phase = 0; m_hold = 0; m_mode = 0;
      m_acc = 0; m_out = 0; m_tick = 0; m_peak = 0;
    end else begin
      t_sum = 0;
      if (ch_en[0]) t_sum += int'(sample_1);
      if (ch_en[1]) t_sum += int'(sample_2);
      if (ch_en[2]) t_sum += int'(sample_3);
      if (ch_en[3]) t_sum += int'(sample_4);
      if (m_mode == 1) t_out = ((m_acc + m_hold) >= 4096) ? 1 : 0;
      else             t_out = (m_phase < m_hold) ? 1 : 0;
      if (m_phase == 4094 && int'(mode) != m_mode) t_acc = 0;
      else if (m_mode == 1)                        t_acc = (m_acc + m_hold) % 4096;
      else                                         t_acc = m_acc;
      if (peak_clr)            t_peak = m_mix;
      else if (m_mix > m_peak) t_peak = m_mix;
      else                     t_peak = m_peak;
      m_tick = (m_phase == 4094) ? 1 : 0;
      if (m_phase == 4094) begin
        m_hold  = m_mix;
        m_mode  = int'(mode);
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
      m_out  = t_out;
      m_acc  = t_acc;
      m_peak = t_peak;
      m_mix  = t_sum / 4;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (sample_tick !== 1'b1 && cycles < limit);
  endtask

  task automatic test_reset();
    ch_en = 4'hF; sample_1 = 12'hABC; sample_2 = 12'h123; sample_3 = 12'h456; sample_4 = 12'h789;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (audio_out !== 1'b0) begin n_fail++; $display("FAIL reset_audio_out got=%b want=0", audio_out); end
    n_cmp++;
    if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_sample_tick got=%b want=0", sample_tick); end
    n_cmp++;
    if (peak !== 12'h000) begin n_fail++; $display("FAIL reset_peak got=%h want=000", peak); end
    rst_n = 1'b1;
  endtask

  task automatic test_pwm_level();
    int c, ones, bad;
    ch_en = 4'b0001; sample_1 = 12'h800; mode = 1'b0; peak_clr = 1'b0;
    sample_2 = 12'($urandom); sample_3 = 12'($urandom); sample_4 = 12'($urandom);
    do_reset();
    wait_tick(5000, c);
    n_cmp++;
    if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL pwm_first_tick got=%b want=1 after %0d cycles", sample_tick, c); end
    ones = 0; bad = 0;
    repeat (4095) begin
      @(negedge clk);
      if (audio_out === 1'b1) ones++;
      if (audio_out !== 1'(m_out) || sample_tick !== 1'(m_tick) || peak !== 12'(m_peak)) bad++;
    end
    n_cmp++;
    if (ones != 512) begin n_fail++; $display("FAIL pwm_high_count got=%0d want=512", ones); end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL pwm_stream bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_full_scale();
    int c, ones, bad;
    ch_en = 4'hF; sample_1 = 12'hFFF; sample_2 = 12'hFFF; sample_3 = 12'hFFF; sample_4 = 12'hFFF;
    mode = 1'b0; peak_clr = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (peak !== 12'hFFF) begin n_fail++; $display("FAIL full_peak got=%h want=fff", peak); end
    wait_tick(5000, c);
    n_cmp++;
    if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL full_first_tick got=%b want=1 after %0d cycles", sample_tick, c); end
    ones = 0; bad = 0;
    repeat (4095) begin
      @(negedge clk);
      if (audio_out === 1'b1) ones++;
      if (audio_out !== 1'(m_out) || sample_tick !== 1'(m_tick) || peak !== 12'(m_peak)) bad++;
    end
    n_cmp++;
    if (ones != 4095) begin n_fail++; $display("FAIL full_high_count got=%0d want=4095", ones); end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL full_stream bad_cycles=%0d want=0", bad); end
  endtask

  task automatic test_dsm_density();
    int c, ones, bad, run, max_run;
    ch_en = 4'b0001; sample_1 = 12'h400; mode = 1'b1; peak_clr = 1'b0;
    do_reset();
    wait_tick(5000, c);
    n_cmp++;
    if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL dsm_first_tick got=%b want=1 after %0d cycles", sample_tick, c); end
    ones = 0; bad = 0; run = 0; max_run = 0;
    repeat (4096) begin
      @(negedge clk);
      if (audio_out === 1'b1) begin
        ones++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (audio_out !== 1'(m_out) || sample_tick !== 1'(m_tick) || peak !== 12'(m_peak)) bad++;
    end
    n_cmp++;
    if (ones < 255 || ones > 257) begin n_fail++; $display("FAIL dsm_density got=%0d want=256+-1", ones); end
    n_cmp++;
    if (max_run > 1) begin n_fail++; $display("FAIL dsm_max_run got=%0d want<=1", max_run); end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL dsm_stream bad_cycles=%0d want=0", bad); end
  endtask

  // Three periods: DSM (toggle to PWM mid-way), PWM (toggle back to DSM
  // mid-way), then DSM again. The last period starts from a cleared
  // accumulator, giving 511 ones; a stale residue of 3584 would give 512.
  task automatic test_mode_switch();
    int c, ones, ticks, bad;
    int want_ones [3];
    want_ones[0] = 511; want_ones[1] = 512; want_ones[2] = 511;
    ch_en = 4'b0001; sample_1 = 12'h800; mode = 1'b1; peak_clr = 1'b0;
    do_reset();
    wait_tick(5000, c);
    n_cmp++;
    if (sample_tick !== 1'b1) begin n_fail++; $display("FAIL mode_first_tick got=%b want=1 after %0d cycles", sample_tick, c); end
    for (int w = 0; w < 3; w++) begin
      ones = 0; ticks = 0; bad = 0;
      repeat (4095) begin
        @(negedge clk);
        if (audio_out === 1'b1) ones++;
        if (sample_tick === 1'b1) ticks++;
        if (audio_out !== 1'(m_out) || sample_tick !== 1'(m_tick) || peak !== 12'(m_peak)) bad++;
        if (w < 2 && m_phase == 100) mode = ~mode;
      end
      n_cmp++;
      if (ones != want_ones[w]) begin n_fail++; $display("FAIL mode_window%0d_ones got=%0d want=%0d", w, ones, want_ones[w]); end
      n_cmp++;
      if (ticks != 1) begin n_fail++; $display("FAIL mode_window%0d_ticks got=%0d want=1", w, ticks); end
      n_cmp++;
      if (bad != 0) begin n_fail++; $display("FAIL mode_window%0d_stream bad_cycles=%0d want=0", w, bad); end
    end
  endtask

  task automatic test_peak_clear();
    ch_en = 4'b0001; sample_1 = 12'hC00; mode = 1'b0; peak_clr = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (peak !== 12'h300) begin n_fail++; $display("FAIL peak_rise got=%h want=300", peak); end
    sample_1 = 12'h400;
    @(negedge clk);
    n_cmp++;
    if (peak !== 12'h300) begin n_fail++; $display("FAIL peak_hold got=%h want=300", peak); end
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    n_cmp++;
    if (peak !== 12'h100) begin n_fail++; $display("FAIL peak_clear got=%h want=100", peak); end
    sample_1 = 12'h800;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (peak !== 12'h200) begin n_fail++; $display("FAIL peak_after_clear got=%h want=200", peak); end
    sample_1 = 12'h400;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (peak !== 12'h200) begin n_fail++; $display("FAIL peak_no_decay got=%h want=200", peak); end
  endtask

  task automatic test_reset_mid_period();
    int c, ones;
    ch_en = 4'hF; sample_1 = 12'hFFF; sample_2 = 12'hFFF; sample_3 = 12'hFFF; sample_4 = 12'hFFF;
    mode = 1'b0; peak_clr = 1'b0;
    do_reset();
    wait_tick(5000, c);
    c = 0;
    while (m_phase != 2000 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (audio_out !== 1'b1) begin n_fail++; $display("FAIL mid_pre_reset_out got=%b want=1", audio_out); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (audio_out !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out got=%b want=0", audio_out); end
    n_cmp++;
    if (peak !== 12'h000) begin n_fail++; $display("FAIL mid_reset_peak got=%h want=000", peak); end
    rst_n = 1'b1;
    c = 0; ones = 0;
    do begin
      @(negedge clk);
      c++;
      if (audio_out === 1'b1) ones++;
    end while (sample_tick !== 1'b1 && c < 5000);
    n_cmp++;
    if (c != 4095) begin n_fail++; $display("FAIL mid_first_tick_latency got=%0d want=4095", c); end
    n_cmp++;
    if (ones != 0) begin n_fail++; $display("FAIL mid_first_period_ones got=%0d want=0", ones); end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    repeat (9000) begin
      @(negedge clk);
      if (audio_out !== 1'(m_out) || sample_tick !== 1'(m_tick) || peak !== 12'(m_peak)) bad++;
      sample_1 = 12'($urandom);
      sample_2 = 12'($urandom);
      sample_3 = 12'($urandom);
      sample_4 = 12'($urandom);
      ch_en    = 4'($urandom);
      mode     = 1'($urandom_range(0, 1));
      peak_clr = ($urandom_range(0, 15) == 0);
    end
    peak_clr = 1'b0;
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL random_stream bad_cycles=%0d want=0", bad); end
  endtask

  initial begin
    test_reset();
    test_pwm_level();
    test_full_scale();
    test_dsm_density();
    test_mode_switch();
    test_peak_clear();
    test_reset_mid_period();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
